// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares the single main-memory block port between the instruction cache and
// the data cache. Block reads and write-backs are serialised, and read data is
// routed back to whichever cache asked for it. The data cache has fixed
// priority. A starvation guard forces an instruction fetch through after
// STARVE_LIMIT consecutive data grants that were made while a fetch was waiting.
//
// Ports
//   CLK, RESET                  clock, asynchronous active-low reset
//   I_READ, I_ADDRESS           icache block-read request and address
//   I_READDATA, I_BUSYWAIT      block returned to icache, icache stall (comb)
//   D_READ, D_WRITE             dcache block-read / write-back requests
//   D_ADDRESS, D_WRITEDATA      dcache block address and write-back block
//   D_READDATA, D_BUSYWAIT      block returned to dcache, dcache stall (comb)
//   M_READ, M_WRITE             memory strobes (registered)
//   M_ADDRESS, M_WRITEDATA      memory block address and write data (registered)
//   M_READDATA, M_BUSYWAIT      memory read data and busy flag

module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    // instruction cache side
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    // data cache side
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    // main memory side
    output logic                  M_READ,
    output logic                  M_WRITE,
    output logic [ADDR_WIDTH-1:0] M_ADDRESS,
    output logic [DATA_WIDTH-1:0] M_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] M_READDATA,
    input  logic                  M_BUSYWAIT
);

    // Starvation counter covers the full 1..15 limit range.
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_I_ACC = 3'd1;
    localparam logic [2:0] S_D_ACC = 3'd2;
    localparam logic [2:0] S_I_REL = 3'd3;
    localparam logic [2:0] S_D_REL = 3'd4;

    logic [2:0]            state_q,   state_d;
    logic                  m_read_q,  m_read_d;
    logic                  m_write_q, m_write_d;
    logic [ADDR_WIDTH-1:0] m_addr_q,  m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]      starve_q,  starve_d;
    logic                  started_q, started_d;

    logic d_req;
    logic acc_done;

    assign d_req    = D_READ | D_WRITE;
    // The access is only finished once memory has been seen busy and then idle.
    assign acc_done = started_q & ~M_BUSYWAIT;

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            starve_q  <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            starve_q  <= starve_d;
            started_q <= started_d;
        end
    end

    // Arbitration, access sequencing and read-data steering.
    always_comb begin
        state_d   = state_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        starve_d  = starve_q;
        started_d = started_q;

        case (state_q)
            S_IDLE: begin
                if (d_req && I_READ && (starve_q == STARVE_MAX)) begin
                    // Fetch has waited long enough: override data priority.
                    state_d  = S_I_ACC;
                    starve_d = '0;
                    m_read_d = 1'b1;
                    m_addr_d = I_ADDRESS;
                end else if (d_req) begin
                    state_d  = S_D_ACC;
                    m_addr_d = D_ADDRESS;
                    if (I_READ) begin
                        starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX
                                                            : starve_q + CNT_W'(1);
                    end else begin
                        starve_d = '0;
                    end
                    // A simultaneous read is dropped; the dcache re-issues it.
                    if (D_WRITE) begin
                        m_write_d = 1'b1;
                        m_wdata_d = D_WRITEDATA;
                    end else begin
                        m_read_d  = 1'b1;
                    end
                end else if (I_READ) begin
                    state_d  = S_I_ACC;
                    starve_d = '0;
                    m_read_d = 1'b1;
                    m_addr_d = I_ADDRESS;
                end
            end

            S_I_ACC: begin
                started_d = started_q | M_BUSYWAIT;
                if (acc_done) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    started_d = 1'b0;
                    i_rdata_d = M_READDATA;
                    state_d   = S_I_REL;
                end
            end

            S_D_ACC: begin
                started_d = started_q | M_BUSYWAIT;
                if (acc_done) begin
                    if (m_read_q) begin
                        d_rdata_d = M_READDATA;
                    end
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    started_d = 1'b0;
                    state_d   = S_D_REL;
                end
            end

            S_I_REL, S_D_REL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                started_d = 1'b0;
            end
        endcase
    end

    // Stalls drop only during the requester's release cycle.
    assign I_BUSYWAIT  = I_READ & (state_q != S_I_REL);
    assign D_BUSYWAIT  = d_req  & (state_q != S_D_REL);

    assign M_READ      = m_read_q;
    assign M_WRITE     = m_write_q;
    assign M_ADDRESS   = m_addr_q;
    assign M_WRITEDATA = m_wdata_q;
    assign I_READDATA  = i_rdata_q;
    assign D_READDATA  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Testbench for mem_port_arbiter: behavioural block memory with programmable
// latency, a grant scoreboard watching the memory port, and per-port read-data
// scoreboards filled when requests are issued.

module tb_mem_port_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 128;
    localparam int unsigned SL = 4;

    logic          CLK;
    logic          RESET;
    logic          I_READ;
    logic [AW-1:0] I_ADDRESS;
    logic [DW-1:0] I_READDATA;
    logic          I_BUSYWAIT;
    logic          D_READ;
    logic          D_WRITE;
    logic [AW-1:0] D_ADDRESS;
    logic [DW-1:0] D_WRITEDATA;
    logic [DW-1:0] D_READDATA;
    logic          D_BUSYWAIT;
    logic          M_READ;
    logic          M_WRITE;
    logic [AW-1:0] M_ADDRESS;
    logic [DW-1:0] M_WRITEDATA;
    logic [DW-1:0] M_READDATA;
    logic          M_BUSYWAIT;

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(SL)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .I_READ     (I_READ),
        .I_ADDRESS  (I_ADDRESS),
        .I_READDATA (I_READDATA),
        .I_BUSYWAIT (I_BUSYWAIT),
        .D_READ     (D_READ),
        .D_WRITE    (D_WRITE),
        .D_ADDRESS  (D_ADDRESS),
        .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA (D_READDATA),
        .D_BUSYWAIT (D_BUSYWAIT),
        .M_READ     (M_READ),
        .M_WRITE    (M_WRITE),
        .M_ADDRESS  (M_ADDRESS),
        .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA (M_READDATA),
        .M_BUSYWAIT (M_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Power-on contents: every byte of block a is 8'hA0 ^ a (block 5 = all A5).
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [7:0] b;
        b = 8'hA0 ^ {2'b00, a};
        return {16{b}};
    endfunction

    // ---------------- behavioural memory ----------------
    logic [DW-1:0] mem_arr [64];
    int            mem_lat;
    int            mem_cnt;
    logic          mem_hold;
    logic [AW-1:0] mem_a;
    logic          mem_w;
    logic [DW-1:0] mem_wd;

    // Accepts a strobe one cycle after it appears, stays busy mem_lat cycles,
    // then waits for the strobe to drop before accepting another.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            M_BUSYWAIT <= 1'b0;
            M_READDATA <= '0;
            mem_cnt    <= 0;
            mem_hold   <= 1'b0;
            mem_a      <= '0;
            mem_w      <= 1'b0;
            mem_wd     <= '0;
            for (int i = 0; i < 64; i++) mem_arr[i] <= pat(AW'(i));
        end else if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) begin
                M_BUSYWAIT <= 1'b0;
                mem_hold   <= 1'b1;
                if (mem_w) mem_arr[mem_a] <= mem_wd;
                else       M_READDATA     <= mem_arr[mem_a];
            end
        end else if ((M_READ || M_WRITE) && !mem_hold) begin
            M_BUSYWAIT <= 1'b1;
            mem_cnt    <= mem_lat;
            mem_a      <= M_ADDRESS;
            mem_w      <= M_WRITE;
            mem_wd     <= M_WRITEDATA;
        end else if (!(M_READ || M_WRITE)) begin
            mem_hold   <= 1'b0;
        end
    end

    // ---------------- grant scoreboard ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } grant_t;

    grant_t        exp_grants[$];
    grant_t        mon_g;
    logic          strobe_prev;

    task automatic expect_grant(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        grant_t g;
        g.wr = wr; g.addr = a; g.wdata = wd;
        exp_grants.push_back(g);
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            strobe_prev <= 1'b0;
        end else begin
            check_b("single_strobe", M_READ & M_WRITE, 1'b0);
            if ((M_READ || M_WRITE) && !strobe_prev) begin
                if (exp_grants.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_unexpected: got strobe at addr %h, required none", M_ADDRESS);
                end else begin
                    mon_g = exp_grants.pop_front();
                    check_b("grant_write", M_WRITE, mon_g.wr);
                    check_b("grant_read",  M_READ,  ~mon_g.wr);
                    check_d("grant_addr",  DW'(M_ADDRESS), DW'(mon_g.addr));
                    if (mon_g.wr) check_d("grant_wdata", M_WRITEDATA, mon_g.wdata);
                end
            end
            strobe_prev <= M_READ | M_WRITE;
        end
    end

    // ---------------- requester drivers ----------------
    logic [DW-1:0] i_rd_q[$];
    logic [DW-1:0] d_rd_q[$];
    time           i_rel_t;
    time           d_rel_t;

    task automatic i_req(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input bit hold, output int cyc);
        int            n;
        bit            done;
        logic [DW-1:0] e;
        @(negedge CLK);
        I_ADDRESS = a;
        I_READ    = 1'b1;
        i_rd_q.push_back(exp);
        n = 0; done = 0;
        while (!done && n < 200) begin
            @(negedge CLK);
            n++;
            if (!I_BUSYWAIT) done = 1;
        end
        cyc = n;
        e = i_rd_q.pop_front();
        if (!done) begin
            check_i("i_release_timeout", n, -1);
        end else begin
            i_rel_t = $time;
            check_d("i_readdata", I_READDATA, e);
            check_b("i_rel_strobes", M_READ | M_WRITE, 1'b0);
            if (hold) begin
                @(negedge CLK);
                check_b("i_busy_one_cycle", I_BUSYWAIT, 1'b1);
            end
        end
        I_READ = 1'b0;
    endtask

    task automatic d_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp);
        int            n;
        bit            done;
        logic [DW-1:0] prev;
        logic [DW-1:0] e;
        @(negedge CLK);
        prev        = D_READDATA;
        D_ADDRESS   = a;
        D_WRITEDATA = wd;
        D_READ      = rd;
        D_WRITE     = wr;
        if (rd && !wr) d_rd_q.push_back(exp);
        n = 0; done = 0;
        while (!done && n < 200) begin
            @(negedge CLK);
            n++;
            if (!D_BUSYWAIT) done = 1;
        end
        if (!done) begin
            check_i("d_release_timeout", n, -1);
            if (rd && !wr) e = d_rd_q.pop_front();
        end else begin
            d_rel_t = $time;
            if (rd && !wr) begin
                e = d_rd_q.pop_front();
                check_d("d_readdata", D_READDATA, e);
            end else begin
                check_d("d_readdata_hold", D_READDATA, prev);
            end
            check_b("d_rel_strobes", M_READ | M_WRITE, 1'b0);
        end
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            is_d;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] exp;
    } vec_t;

    localparam logic [DW-1:0] W1  = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    localparam logic [DW-1:0] W2  = 128'h11112222_33334444_55556666_77778888;
    localparam logic [DW-1:0] W3  = 128'hCAFEBABE_0BADF00D_13572468_ACE0BDF1;
    localparam logic [DW-1:0] W4  = 128'h0F0F0F0F_F0F0F0F0_55AA55AA_AA55AA55;
    localparam logic [DW-1:0] W12 = 128'h12345678_9ABCDEF0_12345678_9ABCDEF0;

    vec_t vecs[9];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int fell;

        RESET       = 1'b0;
        I_READ      = 1'b0;
        I_ADDRESS   = '0;
        D_READ      = 1'b0;
        D_WRITE     = 1'b0;
        D_ADDRESS   = '0;
        D_WRITEDATA = '0;
        mem_lat     = 1;
        i_rel_t     = 0;
        d_rel_t     = 0;

        //               is_d rd    wr    addr   wdata lat exp
        vecs[0] = '{1'b0, 1'b1, 1'b0, 6'h01, '0, 1, pat(6'h01)};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 6'h02, '0, 2, pat(6'h02)};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 6'h03, W1, 3, '0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 6'h03, '0, 1, W1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 6'h03, '0, 4, W1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 6'h3F, W2, 2, '0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 6'h3F, '0, 2, W2};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 6'h00, '0, 3, pat(6'h00)};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 6'h20, '0, 1, pat(6'h20)};

        // Reset values.
        repeat (3) @(negedge CLK);
        check_b("rst_m_read",   M_READ,     1'b0);
        check_b("rst_m_write",  M_WRITE,    1'b0);
        check_d("rst_m_addr",   DW'(M_ADDRESS), '0);
        check_d("rst_m_wdata",  M_WRITEDATA, '0);
        check_d("rst_i_rdata",  I_READDATA,  '0);
        check_d("rst_d_rdata",  D_READDATA,  '0);
        check_b("rst_i_busy",   I_BUSYWAIT,  1'b0);
        check_b("rst_d_busy",   D_BUSYWAIT,  1'b0);
        RESET = 1'b1;

        // Single fetch, 5-cycle memory. Request to release = grant edge +
        // 1 memory accept cycle + 5 busy cycles + completion edge = 8 negedges.
        mem_lat = 5;
        expect_grant(1'b0, 6'h05, '0);
        i_req(6'h05, {16{8'hA5}}, 1'b1, cyc);
        check_i("i_latency", cyc, 8);

        // Table of isolated transactions.
        for (int k = 0; k < 9; k++) begin
            mem_lat = vecs[k].lat;
            expect_grant(vecs[k].wr, vecs[k].addr, vecs[k].wdata);
            if (vecs[k].is_d) d_req(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].exp);
            else              i_req(vecs[k].addr, vecs[k].exp, 1'b0, cyc);
        end

        // Simultaneous fetch and write-back: data side wins.
        mem_lat = 3;
        expect_grant(1'b1, 6'h12, W12);
        expect_grant(1'b0, 6'h10, '0);
        fork
            i_req(6'h10, pat(6'h10), 1'b0, cyc);
            d_req(1'b0, 1'b1, 6'h12, W12, '0);
        join
        check_b("i_after_d_release", i_rel_t > d_rel_t, 1'b1);

        // Starvation guard: four data grants, then the fetch is forced.
        mem_lat = 1;
        for (int k = 0; k < 4; k++) expect_grant(1'b0, AW'(6'h21 + k), '0);
        expect_grant(1'b0, 6'h11, '0);
        expect_grant(1'b0, 6'h25, '0);
        fork
            i_req(6'h11, pat(6'h11), 1'b0, cyc);
            begin
                for (int k = 0; k < 5; k++) d_req(1'b1, 1'b0, AW'(6'h21 + k), '0, pat(AW'(6'h21 + k)));
            end
        join

        // Read and write together: only the write-back runs; re-read sees it.
        mem_lat = 2;
        expect_grant(1'b1, 6'h30, W3);
        d_req(1'b1, 1'b1, 6'h30, W3, '0);
        expect_grant(1'b0, 6'h30, '0);
        d_req(1'b1, 1'b0, 6'h30, '0, W3);

        // Asynchronous reset in the middle of a write-back.
        mem_lat = 5;
        expect_grant(1'b1, 6'h31, W4);
        @(negedge CLK);
        D_ADDRESS   = 6'h31;
        D_WRITEDATA = W4;
        D_WRITE     = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check_b("pre_reset_m_write", M_WRITE, 1'b1);
        #2 RESET = 1'b0;
        #1;
        check_b("arst_m_write", M_WRITE, 1'b0);
        check_b("arst_m_read",  M_READ,  1'b0);
        check_d("arst_m_addr",  DW'(M_ADDRESS), '0);
        check_d("arst_m_wdata", M_WRITEDATA, '0);
        check_d("arst_i_rdata", I_READDATA, '0);
        check_d("arst_d_rdata", D_READDATA, '0);
        D_WRITE   = 1'b0;
        I_ADDRESS = 6'h06;
        I_READ    = 1'b1;
        #1 check_b("arst_i_busy_pending", I_BUSYWAIT, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        mem_lat = 2;
        expect_grant(1'b0, 6'h06, '0);
        RESET = 1'b1;
        i_req(6'h06, pat(6'h06), 1'b0, cyc);

        // Fetch abandoned mid-access: access and release still complete.
        mem_lat = 4;
        expect_grant(1'b0, 6'h07, '0);
        @(negedge CLK);
        I_ADDRESS = 6'h07;
        I_READ    = 1'b1;
        @(negedge CLK);
        check_b("drop_m_read_active", M_READ, 1'b1);
        I_READ = 1'b0;
        fell = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            check_b("drop_i_busy", I_BUSYWAIT, 1'b0);
            if (!M_READ && fell == 0) fell = k + 1;
        end
        check_b("drop_m_read_done", M_READ, 1'b0);
        check_b("drop_completed", fell != 0, 1'b1);
        check_d("drop_i_rdata_captured", I_READDATA, pat(6'h07));
        expect_grant(1'b0, 6'h08, '0);
        d_req(1'b1, 1'b0, 6'h08, '0, pat(6'h08));

        repeat (3) @(negedge CLK);
        check_i("grants_outstanding", exp_grants.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
